mem_port_arbiter: RTL and testbench

- Shares one single-port RAM (1-cycle read latency) between two requesters: the core instruction-fetch port and the execute-stage load/store port.
- Resolves same-cycle conflicts and returns read data to the owner one cycle later.
- Raises a stall request for the core control block when a requester is not granted.
- Sits between the core top level and the unified instruction/data RAM.

---
 rtl/mem_port_arbiter.sv | 183 ++++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Two-port arbiter (fetch and load/store) in front of one single-port RAM with a 1-cycle read latency.
// Define ARB_FAIR_EN to bound how many data grants in a row can go by while a fetch is waiting.
module mem_port_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int MAX_STREAK = 4
) (
    input  logic              clk,
    input  logic              rst_sync,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              i_gnt,
    output logic              i_rvalid,
    output logic [DATA_W-1:0] i_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [1:0]        d_width,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [DATA_W-1:0] d_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [1:0]        mem_width,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              stall_req
);

    typedef enum logic [1:0] {
        OWN_NONE = 2'b00,
        OWN_I    = 2'b01,
        OWN_D    = 2'b10
    } owner_e;

    owner_e            rd_owner_r;
    owner_e            rd_owner_nxt_s;
    logic              i_gnt_s;
    logic              d_gnt_s;
    logic              fair_force_s;
    logic [DATA_W-1:0] i_hold_r;
    logic [DATA_W-1:0] d_hold_r;

`ifdef ARB_FAIR_EN
    localparam int STREAK_W = $clog2(MAX_STREAK + 1);

    logic [STREAK_W-1:0] streak_r;

    // Fetch wins a contested cycle once data has taken MAX_STREAK grants in a row.
    always_comb begin
        fair_force_s = i_req && d_req && (streak_r == STREAK_W'(MAX_STREAK));
    end

    // Count data grants that went by while fetch was waiting.
    always_ff @(posedge clk or posedge rst_sync) begin
        if (rst_sync) begin
            streak_r <= {STREAK_W{1'b0}};
        end else if (i_gnt_s || !i_req) begin
            streak_r <= {STREAK_W{1'b0}};
        end else if (d_gnt_s) begin
            streak_r <= streak_r + {{(STREAK_W-1){1'b0}}, 1'b1};
        end else begin
            streak_r <= streak_r;
        end
    end
`else
    // Strict data priority; the streak limit only matters when fairness is built in.
    always_comb begin
        fair_force_s = (MAX_STREAK < 0);
    end
`endif

    // Same-cycle grant: data first unless the fairness limit hands the slot to fetch.
    always_comb begin
        i_gnt_s = 1'b0;
        d_gnt_s = 1'b0;
        if (rst_sync) begin
            i_gnt_s = 1'b0;
        end else if (fair_force_s) begin
            i_gnt_s = 1'b1;
        end else if (d_req) begin
            d_gnt_s = 1'b1;
        end else if (i_req) begin
            i_gnt_s = 1'b1;
        end else begin
            d_gnt_s = 1'b0;
        end
    end

    // RAM request mux; all fields are zero when nobody is granted.
    always_comb begin
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_width = 2'b00;
        mem_addr  = {ADDR_W{1'b0}};
        mem_wdata = {DATA_W{1'b0}};
        if (d_gnt_s) begin
            mem_en    = 1'b1;
            mem_we    = d_we;
            mem_width = d_width;
            mem_addr  = d_addr;
            mem_wdata = d_wdata;
        end else if (i_gnt_s) begin
            mem_en    = 1'b1;
            mem_width = 2'b10;
            mem_addr  = i_addr;
        end else begin
            mem_en = 1'b0;
        end
    end

    // Grant and stall outputs.
    always_comb begin
        i_gnt     = i_gnt_s;
        d_gnt     = d_gnt_s;
        stall_req = !rst_sync && ((i_req && !i_gnt_s) || (d_req && !d_gnt_s));
    end

    // Read-owner state register; reset drops any read still in flight.
    always_ff @(posedge clk or posedge rst_sync) begin
        if (rst_sync) begin
            rd_owner_r <= OWN_NONE;
        end else begin
            rd_owner_r <= rd_owner_nxt_s;
        end
    end

    // Next owner: whoever issued a read this cycle; stores return nothing.
    always_comb begin
        rd_owner_nxt_s = OWN_NONE;
        if (i_gnt_s) begin
            rd_owner_nxt_s = OWN_I;
        end else if (d_gnt_s && !d_we) begin
            rd_owner_nxt_s = OWN_D;
        end else begin
            rd_owner_nxt_s = OWN_NONE;
        end
    end

    // Return path: RAM data passes straight through on the valid cycle and is held afterwards.
    always_comb begin
        i_rvalid = 1'b0;
        d_rvalid = 1'b0;
        i_rdata  = i_hold_r;
        d_rdata  = d_hold_r;
        case (rd_owner_r)
            OWN_I: begin
                i_rvalid = 1'b1;
                i_rdata  = mem_rdata;
            end
            OWN_D: begin
                d_rvalid = 1'b1;
                d_rdata  = mem_rdata;
            end
            OWN_NONE: begin
                i_rvalid = 1'b0;
            end
            default: begin
                d_rvalid = 1'b0;
            end
        endcase
    end

    // Capture returned data so each port keeps its last read value.
    always_ff @(posedge clk or posedge rst_sync) begin
        if (rst_sync) begin
            i_hold_r <= {DATA_W{1'b0}};
            d_hold_r <= {DATA_W{1'b0}};
        end else if (rd_owner_r == OWN_I) begin
            i_hold_r <= mem_rdata;
            d_hold_r <= d_hold_r;
        end else if (rd_owner_r == OWN_D) begin
            i_hold_r <= i_hold_r;
            d_hold_r <= mem_rdata;
        end else begin
            i_hold_r <= i_hold_r;
            d_hold_r <= d_hold_r;
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: a cycle model checked every negedge plus literal spot checks.
module tb_mem_port_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int MS = 4;

    logic          clk      = 1'b0;
    logic          rst_sync = 1'b1;
    logic          i_req    = 1'b0;
    logic [AW-1:0] i_addr   = '0;
    logic          i_gnt;
    logic          i_rvalid;
    logic [DW-1:0] i_rdata;
    logic          d_req    = 1'b0;
    logic          d_we     = 1'b0;
    logic [1:0]    d_width  = 2'b10;
    logic [AW-1:0] d_addr   = '0;
    logic [DW-1:0] d_wdata  = '0;
    logic          d_gnt;
    logic          d_rvalid;
    logic [DW-1:0] d_rdata;
    logic          mem_en;
    logic          mem_we;
    logic [1:0]    mem_width;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata = '0;
    logic          stall_req;

    int checks = 0;
    int errors = 0;

    mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_STREAK(MS)) dut (
        .clk(clk), .rst_sync(rst_sync),
        .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rvalid(i_rvalid), .i_rdata(i_rdata),
        .d_req(d_req), .d_we(d_we), .d_width(d_width), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_width(mem_width), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .stall_req(stall_req)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Model state: who gets data back next cycle (0 none, 1 fetch, 2 data), last returned words, data run length.
    int            pend_m   = 0;
    int            streak_m = 0;
    logic [DW-1:0] hold_i_m = '0;
    logic [DW-1:0] hold_d_m = '0;
    int            pend_n   = 0;
    int            streak_n = 0;
    logic [DW-1:0] hold_i_n = '0;
    logic [DW-1:0] hold_d_n = '0;

`ifdef ARB_FAIR_EN
    localparam bit FAIR = 1'b1;
`else
    localparam bit FAIR = 1'b0;
`endif

    // Compare process: every negedge, derive expected outputs from the arbitration rules.
    always @(negedge clk) begin
        int winner;
        if (rst_sync) begin
            chk("rst_i_gnt", i_gnt, 0);       chk("rst_d_gnt", d_gnt, 0);
            chk("rst_i_rvalid", i_rvalid, 0); chk("rst_d_rvalid", d_rvalid, 0);
            chk("rst_i_rdata", i_rdata, 0);   chk("rst_d_rdata", d_rdata, 0);
            chk("rst_mem_en", mem_en, 0);     chk("rst_mem_we", mem_we, 0);
            chk("rst_mem_addr", mem_addr, 0); chk("rst_stall", stall_req, 0);
        end else begin
            if (i_req && d_req)
                winner = (FAIR && streak_m >= MS) ? 1 : 2;
            else if (d_req)
                winner = 2;
            else if (i_req)
                winner = 1;
            else
                winner = 0;
            chk("m_i_gnt", i_gnt, winner == 1);
            chk("m_d_gnt", d_gnt, winner == 2);
            chk("m_mem_en", mem_en, winner != 0);
            chk("m_mem_we", mem_we, (winner == 2) && d_we);
            chk("m_mem_width", mem_width, winner == 2 ? d_width : (winner == 1 ? 2 : 0));
            chk("m_mem_addr", mem_addr, winner == 2 ? d_addr : (winner == 1 ? i_addr : 0));
            chk("m_mem_wdata", mem_wdata, winner == 2 ? d_wdata : 0);
            chk("m_stall", stall_req, (i_req && winner != 1) || (d_req && winner != 2));
            chk("m_i_rvalid", i_rvalid, pend_m == 1);
            chk("m_d_rvalid", d_rvalid, pend_m == 2);
            chk("m_i_rdata", i_rdata, pend_m == 1 ? mem_rdata : hold_i_m);
            chk("m_d_rdata", d_rdata, pend_m == 2 ? mem_rdata : hold_d_m);
            pend_n   = (winner == 1) ? 1 : ((winner == 2 && !d_we) ? 2 : 0);
            streak_n = (!i_req || winner == 1) ? 0 : (winner == 2 ? streak_m + 1 : streak_m);
            hold_i_n = (pend_m == 1) ? mem_rdata : hold_i_m;
            hold_d_n = (pend_m == 2) ? mem_rdata : hold_d_m;
        end
    end

    // Model commit on the clock edge; reset clears it asynchronously like the design.
    always @(posedge clk or posedge rst_sync) begin
        if (rst_sync) begin
            pend_m <= 0; streak_m <= 0; hold_i_m <= '0; hold_d_m <= '0;
        end else begin
            pend_m <= pend_n; streak_m <= streak_n; hold_i_m <= hold_i_n; hold_d_m <= hold_d_n;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        i_req = 1'b0; d_req = 1'b0; d_we = 1'b0; d_width = 2'b10;
        i_addr = '0; d_addr = '0; d_wdata = '0;
    endtask

    task automatic load(input logic [AW-1:0] a);
        d_req = 1'b1; d_we = 1'b0; d_width = 2'b10; d_addr = a; d_wdata = '0;
    endtask

    initial begin
        logic [9:0] pat;
        logic [9:0] exp_pat;
        pat = '0;
        @(negedge clk);
        chk("reset_i_rdata", i_rdata, 0);
        chk("reset_mem_en", mem_en, 0);
        step();
        rst_sync = 1'b0;

        // Fetch-only read
        i_req = 1'b1; i_addr = 32'h100;
        @(negedge clk);
        chk("fetch_gnt", i_gnt, 1);     chk("fetch_en", mem_en, 1);
        chk("fetch_we", mem_we, 0);     chk("fetch_addr", mem_addr, 32'h100);
        chk("fetch_stall", stall_req, 0);
        step();
        idle(); mem_rdata = 32'h00500093;
        @(negedge clk);
        chk("fetch_rvalid", i_rvalid, 1); chk("fetch_rdata", i_rdata, 32'h00500093);
        chk("fetch_stall2", stall_req, 0);
        step();
        mem_rdata = 32'h0;
        @(negedge clk);
        chk("fetch_rvalid_drop", i_rvalid, 0); chk("fetch_rdata_hold", i_rdata, 32'h00500093);
        step();

        // Conflict: data wins, fetch goes next cycle
        i_req = 1'b1; i_addr = 32'h104; load(32'h2000);
        @(negedge clk);
        chk("conf_d_gnt", d_gnt, 1); chk("conf_i_gnt", i_gnt, 0);
        chk("conf_stall", stall_req, 1); chk("conf_addr", mem_addr, 32'h2000);
        step();
        d_req = 1'b0; mem_rdata = 32'hDEAD0001;
        @(negedge clk);
        chk("conf_d_rvalid", d_rvalid, 1); chk("conf_d_rdata", d_rdata, 32'hDEAD0001);
        chk("conf_i_gnt2", i_gnt, 1);      chk("conf_addr2", mem_addr, 32'h104);
        step();
        idle(); mem_rdata = 32'h11112222;
        @(negedge clk);
        chk("conf_i_rvalid", i_rvalid, 1); chk("conf_i_rdata", i_rdata, 32'h11112222);
        step();

        // Byte store: no read data follows
        d_req = 1'b1; d_we = 1'b1; d_width = 2'b00; d_addr = 32'h2003; d_wdata = 32'hAB;
        mem_rdata = 32'h0;
        @(negedge clk);
        chk("st_we", mem_we, 1); chk("st_width", mem_width, 0); chk("st_wdata", mem_wdata, 32'hAB);
        step();
        idle(); mem_rdata = 32'h77777777;
        @(negedge clk);
        chk("st_no_rvalid", d_rvalid, 0); chk("st_d_rdata_hold", d_rdata, 32'hDEAD0001);
        step();

        // Back-to-back loads
        load(32'h10);
        step();
        load(32'h14); mem_rdata = 32'd1;
        @(negedge clk);
        chk("b2b_v1", d_rvalid, 1); chk("b2b_d1", d_rdata, 1); chk("b2b_a2", mem_addr, 32'h14);
        step();
        load(32'h18); mem_rdata = 32'd2;
        @(negedge clk);
        chk("b2b_v2", d_rvalid, 1); chk("b2b_d2", d_rdata, 2);
        step();
        idle(); mem_rdata = 32'd3;
        @(negedge clk);
        chk("b2b_v3", d_rvalid, 1); chk("b2b_d3", d_rdata, 3);
        step();
        mem_rdata = 32'h0;
        @(negedge clk);
        chk("b2b_end", d_rvalid, 0); chk("b2b_hold", d_rdata, 3);
        step();

        // Reset asserted while a fetch read is returning
        i_req = 1'b1; i_addr = 32'h200;
        step();
        idle(); mem_rdata = 32'h55;
        chk("rst_pre_rvalid", i_rvalid, 1);
        rst_sync = 1'b1;
        #1;
        chk("rst_mid_rvalid", i_rvalid, 0); chk("rst_mid_rdata", i_rdata, 0);
        step();
        step();
        rst_sync = 1'b0; mem_rdata = 32'h0;
        @(negedge clk);
        chk("rst_after_rvalid", i_rvalid, 0);
        step();

        // Both requesters held high for ten cycles
        i_req = 1'b1; i_addr = 32'h300; load(32'h400);
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            pat = {pat[8:0], d_gnt};
            chk("one_grant", {1'b0, i_gnt ^ d_gnt}, 1);
            step();
        end
`ifdef ARB_FAIR_EN
        exp_pat = 10'b1111011110;
`else
        exp_pat = 10'b1111111111;
`endif
        chk("grant_pattern", pat, exp_pat);
        idle();
        step();
        step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
